// File: rtl/module_7seg_scan_ctrl_pkg.sv
// Shared types and constants for the 4-digit 7-segment scan controller.
package deco_7seg_pkg;

    localparam int unsigned NUM_DIGITS = 4;
    localparam int unsigned DIGIT_W    = 4;
    localparam logic [NUM_DIGITS-1:0] ANODES_OFF = 4'b1111;

    typedef enum logic [1:0] {
        IDLE,
        BLANK,
        DRIVE
    } scan_state_t;

    // Active-low anode pattern with only the selected digit enabled.
    function automatic logic [NUM_DIGITS-1:0] anode_pattern(input logic [1:0] sel);
        return ANODES_OFF & ~(NUM_DIGITS'(1) << sel);
    endfunction

endpackage

// File: rtl/module_7seg_scan_ctrl_if.sv
// Display-side bundle of the scan controller: enable and digit values in,
// mux select, anode enables and frame tick out.
interface module_7seg_scan_ctrl_if;
    import deco_7seg_pkg::*;

    logic                  en;
    logic [DIGIT_W-1:0]    digit_0;
    logic [DIGIT_W-1:0]    digit_1;
    logic [DIGIT_W-1:0]    digit_2;
    logic [DIGIT_W-1:0]    digit_3;
    logic [1:0]            digit_sel;
    logic [NUM_DIGITS-1:0] anodes;
    logic                  frame_tick;

    modport master (
        output en, digit_0, digit_1, digit_2, digit_3,
        input  digit_sel, anodes, frame_tick
    );

    modport slave (
        input  en, digit_0, digit_1, digit_2, digit_3,
        output digit_sel, anodes, frame_tick
    );

endinterface

// File: rtl/module_slot_counter.sv
// Slot duration counter: counts 0..last while run is high, wraps to 0 on
// the terminal count (done), and clears synchronously on clear.
module module_slot_counter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             run,
    input  logic [WIDTH-1:0] last,
    output logic [WIDTH-1:0] count,
    output logic             done
);

    assign done = run && (count == last);

    // Count cycles of the current phase, restarting at its terminal count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (run) begin
            count <= done ? '0 : count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/module_7seg_scan_ctrl.sv
// Time-multiplexed refresh controller for a 4-digit 7-segment display.
// Each digit slot is BLANK_CYCLES of all anodes off followed by a drive
// window; frame_tick marks the start of every frame after the first.
// Optional macro LEADING_ZERO_BLANK_EN keeps leading zero digits dark,
// using a suppress mask latched at each frame start.
module module_7seg_scan_ctrl
    import deco_7seg_pkg::*;
#(
    parameter int unsigned REFRESH_DIV  = 25000,
    parameter int unsigned BLANK_CYCLES = 500
) (
    input  logic                    clk,
    input  logic                    rst_n,
    module_7seg_scan_ctrl_if.slave  bus
);

    localparam int unsigned DRIVE_CYCLES = REFRESH_DIV - BLANK_CYCLES;
    localparam int unsigned CNT_W        = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0] DRIVE_LAST = CNT_W'(DRIVE_CYCLES - 1);

    if (BLANK_CYCLES < 1 || BLANK_CYCLES >= REFRESH_DIV) begin : g_param_check
        $error("module_7seg_scan_ctrl: need 1 <= BLANK_CYCLES < REFRESH_DIV");
    end

    scan_state_t           state;
    logic [1:0]            digit_sel_q;
    logic [NUM_DIGITS-1:0] anodes_q;
    logic                  frame_tick_q;

    logic                  cnt_clear;
    logic                  cnt_run;
    logic [CNT_W-1:0]      cnt_last;
    logic [CNT_W-1:0]      cnt_value;
    logic                  cnt_done;
    logic                  last_digit;
    logic                  frame_start;
    logic                  digit_enabled;

    assign cnt_clear   = (state == IDLE) || !bus.en;
    assign cnt_run     = (state != IDLE);
    assign cnt_last    = (state == BLANK) ? BLANK_LAST : DRIVE_LAST;
    assign last_digit  = (digit_sel_q == 2'(NUM_DIGITS - 1));
    assign frame_start = bus.en && ((state == IDLE) ||
                                    (state == DRIVE && cnt_done && last_digit));

    module_slot_counter #(
        .WIDTH (CNT_W)
    ) u_slot_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (cnt_clear),
        .run   (cnt_run),
        .last  (cnt_last),
        .count (cnt_value),
        .done  (cnt_done)
    );

`ifdef LEADING_ZERO_BLANK_EN
    logic [NUM_DIGITS-1:0] suppress;
    logic [NUM_DIGITS-1:0] suppress_next;

    // A digit is dark when it and every more significant digit are zero.
    always_comb begin
        suppress_next    = '0;
        suppress_next[3] = (bus.digit_3 == '0);
        suppress_next[2] = suppress_next[3] && (bus.digit_2 == '0);
        suppress_next[1] = suppress_next[2] && (bus.digit_1 == '0);
    end

    // Capture the suppress mask once per frame so the display is stable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            suppress <= '0;
        end else if (frame_start) begin
            suppress <= suppress_next;
        end
    end

    assign digit_enabled = !suppress[digit_sel_q];
`else
    assign digit_enabled = 1'b1;
`endif

    // Scan FSM: blank gap, then drive the selected digit, then advance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            digit_sel_q  <= '0;
            anodes_q     <= ANODES_OFF;
            frame_tick_q <= 1'b0;
        end else begin
            frame_tick_q <= 1'b0;
            if (!bus.en) begin
                state       <= IDLE;
                digit_sel_q <= '0;
                anodes_q    <= ANODES_OFF;
            end else begin
                case (state)
                    IDLE: begin
                        state       <= BLANK;
                        digit_sel_q <= '0;
                        anodes_q    <= ANODES_OFF;
                    end
                    BLANK: begin
                        if (cnt_done) begin
                            state    <= DRIVE;
                            anodes_q <= digit_enabled ? anode_pattern(digit_sel_q) : ANODES_OFF;
                        end
                    end
                    DRIVE: begin
                        if (cnt_done) begin
                            state        <= BLANK;
                            anodes_q     <= ANODES_OFF;
                            digit_sel_q  <= digit_sel_q + 2'd1;
                            frame_tick_q <= last_digit;
                        end
                    end
                    default: begin
                        state    <= IDLE;
                        anodes_q <= ANODES_OFF;
                    end
                endcase
            end
        end
    end

    assign bus.digit_sel  = digit_sel_q;
    assign bus.anodes     = anodes_q;
    assign bus.frame_tick = frame_tick_q;

endmodule

// File: tb/tb_module_7seg_scan_ctrl.sv
// Bench for module_7seg_scan_ctrl with REFRESH_DIV=8, BLANK_CYCLES=2.
// Honours LEADING_ZERO_BLANK_EN the same way as the design build.
module tb_module_7seg_scan_ctrl;
    import deco_7seg_pkg::*;

    localparam int unsigned R     = 8;
    localparam int unsigned B     = 2;
    localparam int unsigned FRAME = 4 * R;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    module_7seg_scan_ctrl_if bus ();

    module_7seg_scan_ctrl #(
        .REFRESH_DIV  (R),
        .BLANK_CYCLES (B)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference model: k = number of enabled edges since leaving IDLE.
    int unsigned k;
    logic [3:0]  ld [4];
    int          n_checks = 0;
    int          n_fail   = 0;

    function automatic logic digit_driven(input int unsigned sel);
`ifdef LEADING_ZERO_BLANK_EN
        int unsigned msd = 0;
        for (int unsigned i = 0; i < 4; i++)
            if (ld[i] != 4'd0) msd = i;
        return (sel <= msd);
`else
        return (sel < 4);
`endif
    endfunction

    function automatic logic [3:0] exp_anodes();
        int unsigned p;
        int unsigned sel;
        logic [3:0]  one_hot;
        if (k == 0) return 4'hF;
        p   = k - 1;
        sel = (p / R) % 4;
        if ((p % R) < B) return 4'hF;
        if (!digit_driven(sel)) return 4'hF;
        one_hot = 4'd0;
        one_hot[sel] = 1'b1;
        return ~one_hot;
    endfunction

    function automatic logic [1:0] exp_sel();
        if (k == 0) return 2'd0;
        return 2'(((k - 1) / R) % 4);
    endfunction

    function automatic logic exp_tick();
        return (k > 1) && (((k - 1) % FRAME) == 0);
    endfunction

    task automatic tick();
        @(posedge clk);
        if (!rst_n || !bus.en) begin
            k = 0;
        end else begin
            k++;
            if (((k - 1) % FRAME) == 0) begin
                ld[0] = bus.digit_0;
                ld[1] = bus.digit_1;
                ld[2] = bus.digit_2;
                ld[3] = bus.digit_3;
            end
        end
        #1;
    endtask

    task automatic restart();
        bus.en = 1'b0;
        tick();
        bus.en = 1'b1;
    endtask

    task automatic set_digits(input logic [3:0] d3, input logic [3:0] d2,
                              input logic [3:0] d1, input logic [3:0] d0);
        bus.digit_3 = d3;
        bus.digit_2 = d2;
        bus.digit_1 = d1;
        bus.digit_0 = d0;
    endtask

    task automatic test_reset();
        bus.en = 1'b0;
        set_digits(4'd0, 4'd0, 4'd0, 4'd0);
        k = 0;
        #12;
        n_checks++;
        if ({bus.anodes, bus.digit_sel, bus.frame_tick} !== 7'b1111_00_0) begin
            n_fail++;
            $display("FAIL reset_values got=%b exp=%b",
                     {bus.anodes, bus.digit_sel, bus.frame_tick}, 7'b1111_00_0);
        end
        bus.en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if ({bus.anodes, bus.digit_sel, bus.frame_tick} !== 7'b1111_00_0) begin
                n_fail++;
                $display("FAIL reset_hold cyc=%0d got=%b exp=%b", i,
                         {bus.anodes, bus.digit_sel, bus.frame_tick}, 7'b1111_00_0);
            end
        end
        bus.en = 1'b0;
        rst_n  = 1'b1;
        tick();
    endtask

    task automatic test_scan();
        set_digits(4'($urandom_range(1, 15)), 4'($urandom), 4'($urandom), 4'($urandom));
        restart();
        for (int i = 0; i < int'(2 * FRAME + 4); i++) begin
            tick();
            n_checks++;
            if ({bus.anodes, bus.digit_sel, bus.frame_tick} !== {exp_anodes(), exp_sel(), exp_tick()}) begin
                n_fail++;
                $display("FAIL scan k=%0d got=%b exp=%b", k,
                         {bus.anodes, bus.digit_sel, bus.frame_tick}, {exp_anodes(), exp_sel(), exp_tick()});
            end
        end
    endtask

    task automatic test_frame_tick();
        int n_ticks  = 0;
        int first_k  = -1;
        restart();
        for (int i = 0; i < int'(3 * FRAME + 2); i++) begin
            tick();
            if (bus.frame_tick === 1'b1) begin
                n_ticks++;
                if (first_k < 0) first_k = int'(k);
            end
            n_checks++;
            if (bus.frame_tick !== exp_tick()) begin
                n_fail++;
                $display("FAIL frame_tick k=%0d got=%b exp=%b", k, bus.frame_tick, exp_tick());
            end
        end
        n_checks++;
        if (n_ticks != 3) begin
            n_fail++;
            $display("FAIL frame_tick_count got=%0d exp=3", n_ticks);
        end
        n_checks++;
        if (first_k != int'(FRAME + 1)) begin
            n_fail++;
            $display("FAIL frame_tick_first got=%0d exp=%0d", first_k, FRAME + 1);
        end
    endtask

    task automatic test_disable();
        set_digits(4'd9, 4'd1, 4'd2, 4'd3);
        restart();
        while (k < 2 * R + B + 3) tick();
        n_checks++;
        if (bus.anodes !== 4'b1011) begin
            n_fail++;
            $display("FAIL disable_pre got=%b exp=%b", bus.anodes, 4'b1011);
        end
        bus.en = 1'b0;
        tick();
        n_checks++;
        if ({bus.anodes, bus.digit_sel, bus.frame_tick} !== 7'b1111_00_0) begin
            n_fail++;
            $display("FAIL disable_idle got=%b exp=%b",
                     {bus.anodes, bus.digit_sel, bus.frame_tick}, 7'b1111_00_0);
        end
        bus.en = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            n_checks++;
            if ({bus.anodes, bus.digit_sel, bus.frame_tick} !== {exp_anodes(), exp_sel(), exp_tick()}) begin
                n_fail++;
                $display("FAIL disable_resume k=%0d got=%b exp=%b", k,
                         {bus.anodes, bus.digit_sel, bus.frame_tick}, {exp_anodes(), exp_sel(), exp_tick()});
            end
        end
    endtask

    task automatic test_async_reset();
        restart();
        while (k < 2 * R + B + 3) tick();
        #2;
        rst_n = 1'b0;
        k     = 0;
        #1;
        n_checks++;
        if ({bus.anodes, bus.digit_sel, bus.frame_tick} !== 7'b1111_00_0) begin
            n_fail++;
            $display("FAIL async_reset got=%b exp=%b",
                     {bus.anodes, bus.digit_sel, bus.frame_tick}, 7'b1111_00_0);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if ({bus.anodes, bus.digit_sel, bus.frame_tick} !== 7'b1111_00_0) begin
                n_fail++;
                $display("FAIL async_reset_hold cyc=%0d got=%b exp=%b", i,
                         {bus.anodes, bus.digit_sel, bus.frame_tick}, 7'b1111_00_0);
            end
        end
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            n_checks++;
            if ({bus.anodes, bus.digit_sel, bus.frame_tick} !== {exp_anodes(), exp_sel(), exp_tick()}) begin
                n_fail++;
                $display("FAIL async_reset_resume k=%0d got=%b exp=%b", k,
                         {bus.anodes, bus.digit_sel, bus.frame_tick}, {exp_anodes(), exp_sel(), exp_tick()});
            end
        end
    endtask

    task automatic test_leading_zero();
        logic [3:0] seen_low;
        int         found_k;
`ifdef LEADING_ZERO_BLANK_EN
        logic [3:0] exp_a = 4'b0011;
        logic [3:0] exp_b = 4'b0001;
        int         exp_c = int'(FRAME + 3 * R + B + 1);
`else
        logic [3:0] exp_a = 4'b1111;
        logic [3:0] exp_b = 4'b1111;
        int         exp_c = int'(3 * R + B + 1);
`endif
        // Digits 3..0 = 0,0,7,0
        set_digits(4'd0, 4'd0, 4'd7, 4'd0);
        restart();
        seen_low = 4'd0;
        for (int i = 0; i < int'(2 * FRAME); i++) begin
            tick();
            seen_low = seen_low | ~bus.anodes;
            n_checks++;
            if (bus.anodes !== exp_anodes()) begin
                n_fail++;
                $display("FAIL lz_0070 k=%0d got=%b exp=%b", k, bus.anodes, exp_anodes());
            end
        end
        n_checks++;
        if (seen_low !== exp_a) begin
            n_fail++;
            $display("FAIL lz_0070_driven got=%b exp=%b", seen_low, exp_a);
        end
        // All digits zero
        set_digits(4'd0, 4'd0, 4'd0, 4'd0);
        restart();
        seen_low = 4'd0;
        for (int i = 0; i < int'(2 * FRAME); i++) begin
            tick();
            seen_low = seen_low | ~bus.anodes;
        end
        n_checks++;
        if (seen_low !== exp_b) begin
            n_fail++;
            $display("FAIL lz_zero_driven got=%b exp=%b", seen_low, exp_b);
        end
        // digit_3 becomes non-zero mid-frame
        restart();
        while (k < 10) tick();
        bus.digit_3 = 4'd5;
        found_k = -1;
        for (int i = 0; i < 120 && found_k < 0; i++) begin
            tick();
            if (bus.anodes === 4'b0111) found_k = int'(k);
            n_checks++;
            if (bus.anodes !== exp_anodes()) begin
                n_fail++;
                $display("FAIL lz_late k=%0d got=%b exp=%b", k, bus.anodes, exp_anodes());
            end
        end
        n_checks++;
        if (found_k != exp_c) begin
            n_fail++;
            $display("FAIL lz_late_first_0111 got=%0d exp=%0d", found_k, exp_c);
        end
    endtask

    task automatic test_random();
        restart();
        for (int i = 0; i < 400; i++) begin
            bus.en = ($urandom_range(0, 59) != 0);
            if ($urandom_range(0, 9) == 0) begin
                bus.digit_3 = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom);
                bus.digit_2 = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom);
                bus.digit_1 = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom);
                bus.digit_0 = 4'($urandom);
            end
            tick();
            n_checks++;
            if ({bus.anodes, bus.digit_sel, bus.frame_tick} !== {exp_anodes(), exp_sel(), exp_tick()}) begin
                n_fail++;
                $display("FAIL random k=%0d got=%b exp=%b", k,
                         {bus.anodes, bus.digit_sel, bus.frame_tick}, {exp_anodes(), exp_sel(), exp_tick()});
            end
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_frame_tick();
        test_disable();
        test_async_reset();
        test_leading_zero();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/module_7seg_scan_ctrl.md
Name: module_7seg_scan_ctrl

Overview:
- Time-multiplexed refresh controller for the 4-digit 7-segment display.
- Sits directly upstream of the 7-segment decoder/mux stage: its digit_sel output drives the mux select (the former btn input) so each digit's value reaches the shared segment bus in turn.
- Drives the active-low common anodes, with a blanking gap between digits to prevent ghosting.
- Emits a once-per-frame tick for downstream consumers.

Parameters:
- REFRESH_DIV, 25000: clock cycles per digit slot (blank plus drive); must be > BLANK_CYCLES.
- BLANK_CYCLES, 500: cycles at the start of each slot with all anodes off; must be >= 1.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- en  input  1  scan enable; low forces display dark and restarts the scan
- digit_0  input  4  value of digit 0 (least significant); used only by the optional feature
- digit_1  input  4  value of digit 1; optional feature only
- digit_2  input  4  value of digit 2; optional feature only
- digit_3  input  4  value of digit 3 (most significant); optional feature only
- digit_sel  output  2  index of the digit currently selected; feeds the decoder mux select
- anodes  output  4  active-low anode enables; bit i drives digit i
- frame_tick  output  1  one-cycle pulse when digit_sel wraps from 3 to 0

Behaviour:
- Single clock domain; reset is asynchronous and active-low.
- Reset values: state=IDLE, digit_sel=2'b00, anodes=4'b1111, frame_tick=0, slot counter=0.
- All outputs are registered; no combinational path from input to output.
- FSM states: IDLE, BLANK, DRIVE.
  - IDLE: anodes=1111, digit_sel=0, counter=0. If en=1, go to BLANK on the next edge.
  - BLANK: anodes=1111 for exactly BLANK_CYCLES cycles, then go to DRIVE.
  - DRIVE: anodes[digit_sel]=0, all other bits 1, for exactly REFRESH_DIV-BLANK_CYCLES cycles. Then digit_sel increments mod 4, counter clears, go to BLANK.
- Slot length is REFRESH_DIV cycles; frame length is 4*REFRESH_DIV cycles.
- Slot counter width is $clog2(REFRESH_DIV). It counts 0..BLANK_CYCLES-1 in BLANK, then 0..DRIVE_CYCLES-1 in DRIVE, clearing at each state change.
- frame_tick is high for exactly the one cycle in which the registered digit_sel first reads 0 after a 3→0 wrap. It does not pulse on leaving IDLE.
- en low in any state: on the next edge go to IDLE, anodes=1111, digit_sel=0, counter=0. Re-enable always restarts at digit 0 BLANK.
- Reset asserted mid-operation: outputs take reset values immediately, without waiting for a clock edge.
- digit_sel changes only on the DRIVE→BLANK transition. The mux output is therefore stable for the whole BLANK and DRIVE window of a slot.
- Elaboration-time assertion fails if BLANK_CYCLES<1 or BLANK_CYCLES>=REFRESH_DIV.

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
- Defined:
  - A 4-bit suppress mask is latched on every entry into BLANK for digit 0 (frame start, including the first after IDLE).
  - Digit i (i=3..1) is suppressed if digit_i and every higher digit equal 0. Digit 0 is never suppressed.
  - In DRIVE, a suppressed digit keeps anodes=1111. Slot timing, digit_sel and frame_tick are unchanged.
  - Digit input changes take effect only at the next frame start.
- Undefined: digit_0..digit_3 are unused, every digit is driven, and there is no mask register.

Decomposition:
- Package deco_7seg_pkg:
  - scan_state_t enum (IDLE, BLANK, DRIVE)
  - NUM_DIGITS=4
  - DIGIT_W=4
  - ANODES_OFF=4'b1111
- Sub-module module_slot_counter (parameterised terminal count; sync clear; done pulse), instantiated once and reused for both BLANK and DRIVE durations.
- Mask logic stays inline.

Test Plan:
All scenarios use REFRESH_DIV=8, BLANK_CYCLES=2.
- Reset: rst_n=0 asserted asynchronously mid-DRIVE of digit 2 → anodes=1111, digit_sel=00 and frame_tick=0 immediately. Outputs hold while rst_n=0.
- Scan sequence: en=1 after reset → anodes repeat 1111×2, 1110×6, 1111×2, 1101×6, 1111×2, 1011×6, 1111×2, 0111×6. digit_sel steps 0,1,2,3, each held 8 cycles.
- Frame tick:
  - frame_tick pulses for 1 cycle every 32 cycles, in the cycle after the digit_sel 3→0 wrap.
  - No pulse on the first frame after leaving IDLE.
- Disable mid-scan: en→0 during digit 2 DRIVE → next cycle IDLE, anodes=1111, digit_sel=0. en→1 → BLANK for digit 0 (2 cycles of 1111), then 1110.
- Leading-zero suppression (LEADING_ZERO_BLANK_EN defined):
  - Digits 3..0 = 0,0,7,0 → anodes bits 3 and 2 never go low; 1101 and 1110 are driven.
  - All digits 0 → only 1110 is ever driven.
  - digit_3 set to 5 mid-frame → 0111 first appears in the following frame.
- Leading-zero suppression disabled (LEADING_ZERO_BLANK_EN undefined): same digit values → all four anodes driven in sequence.
